text_line_buffer: RTL and testbench

Editable 41-character text line that sits directly upstream of the VGA controller and drives its `char` array. It accepts ASCII bytes one at a time from a keyboard or UART decoder and handles printable characters, backspace and line clear. Edits go to a working copy, which is committed to the display array only on a frame-start pulse, so the ASCII writer never sees a half-updated line mid-frame.

---
 rtl/text_line_buffer.sv | 149 ++++++++++++++
 tb/tb_text_line_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/text_line_buffer.sv
// -----------------------------------------------------------------------------
// text_line_buffer
//
// Editable single text line feeding the VGA character array. ASCII bytes edit
// a working copy (printable insert, backspace, CR/LF clear). The working copy
// is copied to the display array only on a frame-start pulse. This keeps the
// character writer from ever seeing a half-edited line while a frame is drawn.
//
// Ports
//   clock_25    : pixel clock, all state updates on its rising edge
//   reset       : synchronous, active-high
//   char_in     : ASCII byte, qualified by char_valid
//   char_valid  : one-cycle strobe
//   frame_start : one-cycle pulse at the start of vertical blanking
//   ready       : high in IDLE, when a strobe will be accepted
//   char_out    : display array, cell 0 is leftmost, 8'd0 is blank
//   cursor      : next write position, 0..N_CHARS
//   full        : cursor == N_CHARS
//   overflow    : sticky drop flag, cleared when a line clear completes
// -----------------------------------------------------------------------------
module text_line_buffer #(
    parameter int N_CHARS = 41
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    input  logic       frame_start,
    output logic       ready,
    output logic [7:0] char_out [0:N_CHARS-1],
    output logic [5:0] cursor,
    output logic       full,
    output logic       overflow
);

    localparam logic [5:0] LAST_IDX = 6'(N_CHARS - 1);
    localparam logic [5:0] MAX_CUR  = 6'(N_CHARS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state_q, state_d;
    logic [5:0] cursor_q, cursor_d;
    logic [5:0] clr_idx_q, clr_idx_d;
    logic       overflow_q, overflow_d;
    logic       dirty_q, dirty_d;
    logic       commit;
    logic [7:0] work_q [0:N_CHARS-1];
    logic [7:0] work_d [0:N_CHARS-1];
    logic [7:0] char_out_q [0:N_CHARS-1];

    logic is_printable;
    logic is_backspace;
    logic is_newline;

    assign is_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign is_backspace = (char_in == 8'h08);
    assign is_newline   = (char_in == 8'h0D) || (char_in == 8'h0A);

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        clr_idx_d  = clr_idx_q;
        overflow_d = overflow_q;
        dirty_d    = dirty_q;
        commit     = 1'b0;
        work_d     = work_q;

        if (state_q == IDLE) begin
            // Commit snapshots the pre-edit work array; clearing dirty first
            // lets a write in the same cycle re-arm it for the next frame.
            if (frame_start && dirty_q) begin
                commit  = 1'b1;
                dirty_d = 1'b0;
            end
            if (char_valid) begin
                if (is_printable) begin
                    if (cursor_q < MAX_CUR) begin
                        work_d[cursor_q] = char_in;
                        cursor_d         = cursor_q + 6'd1;
                        dirty_d          = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (is_backspace) begin
                    if (cursor_q != 6'd0) begin
                        work_d[cursor_q - 6'd1] = 8'd0;
                        cursor_d                = cursor_q - 6'd1;
                        dirty_d                 = 1'b1;
                    end
                end else if (is_newline) begin
                    cursor_d  = 6'd0;
                    clr_idx_d = 6'd0;
                    state_d   = CLEAR;
                end
            end
        end else begin
            // frame_start is ignored here so a partial clear is never shown.
            if (char_valid) begin
                overflow_d = 1'b1;
            end
            work_d[clr_idx_q] = 8'd0;
            clr_idx_d         = clr_idx_q + 6'd1;
            // Completing the clear wins over a strobe dropped in this cycle.
            if (clr_idx_q == LAST_IDX) begin
                dirty_d    = 1'b1;
                overflow_d = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q    <= IDLE;
            cursor_q   <= 6'd0;
            clr_idx_q  <= 6'd0;
            overflow_q <= 1'b0;
            dirty_q    <= 1'b0;
            for (int i = 0; i < N_CHARS; i++) begin
                work_q[i]     <= 8'd0;
                char_out_q[i] <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            clr_idx_q  <= clr_idx_d;
            overflow_q <= overflow_d;
            dirty_q    <= dirty_d;
            for (int i = 0; i < N_CHARS; i++) begin
                work_q[i] <= work_d[i];
                if (commit) begin
                    char_out_q[i] <= work_q[i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_out
            assign char_out[gi] = char_out_q[gi];
        end
    endgenerate

    assign ready    = (state_q == IDLE);
    assign full     = (cursor_q == MAX_CUR);
    assign cursor   = cursor_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_text_line_buffer.sv
module tb_text_line_buffer;
    localparam int N = 41;
    localparam int W = N * 8;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] char_in = 8'd0;
    logic       ready, full, overflow;
    logic [5:0] cursor;
    logic [7:0] char_out_w [0:N-1];

    always #20 clock_25 = ~clock_25;

    text_line_buffer #(.N_CHARS(N)) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .frame_start (frame_start),
        .ready       (ready),
        .char_out    (char_out_w),
        .cursor      (cursor),
        .full        (full),
        .overflow    (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: working line, cursor, flags and the shown display.
    logic [W-1:0] m_work, m_disp;
    int           m_cursor;
    logic         m_overflow, m_dirty;
    logic [W-1:0] sb [$];

    typedef struct {
        logic [7:0] b;
        int         cur;
        logic       fl;
        logic       ov;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [W-1:0] disp_now();
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = char_out_w[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        char_valid = 1'b0;
        frame_start = 1'b0;
        @(negedge clock_25);
        reset = 1'b0;
        m_work = '0; m_disp = '0; m_cursor = 0;
        m_overflow = 1'b0; m_dirty = 1'b0;
        sb.delete();
        check({tag, "_ready"}, W'(ready), W'(1));
        check({tag, "_cursor"}, W'(cursor), W'(0));
        check({tag, "_overflow"}, W'(overflow), W'(0));
        check({tag, "_full"}, W'(full), W'(0));
        check({tag, "_disp"}, disp_now(), '0);
        $display("txn %s: reset", tag);
    endtask

    // One IDLE-state cycle: optional strobe plus optional frame pulse.
    task automatic send(input logic v, input logic [7:0] b, input logic fs, input string tag);
        logic nl;
        nl = v && (b == 8'h0D || b == 8'h0A);
        char_in = b; char_valid = v; frame_start = fs;
        if (fs && m_dirty) begin
            sb.push_back(m_work);
            m_dirty = 1'b0;
        end
        if (v) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                if (m_cursor < N) begin
                    m_work[8*m_cursor +: 8] = b;
                    m_cursor++;
                    m_dirty = 1'b1;
                end else begin
                    m_overflow = 1'b1;
                end
            end else if (b == 8'h08) begin
                if (m_cursor > 0) begin
                    m_cursor--;
                    m_work[8*m_cursor +: 8] = 8'd0;
                    m_dirty = 1'b1;
                end
            end else if (nl) begin
                m_cursor = 0;
            end
        end
        @(negedge clock_25);
        char_valid = 1'b0; frame_start = 1'b0;
        if (sb.size() > 0) m_disp = sb.pop_front();
        check({tag, "_cursor"}, W'(cursor), W'(m_cursor));
        check({tag, "_full"}, W'(full), W'(m_cursor == N));
        check({tag, "_overflow"}, W'(overflow), W'(m_overflow));
        check({tag, "_ready"}, W'(ready), W'(!nl));
        check({tag, "_disp"}, disp_now(), m_disp);
        $display("txn %s: v=%0d b=%02h fs=%0d cursor=%0d ovf=%0d", tag, v, b, fs, cursor, overflow);
    endtask

    initial begin
        logic [W-1:0] d;
        int low;

        tbl[0] = '{8'h41, 1, 1'b0, 1'b0};
        tbl[1] = '{8'h42, 2, 1'b0, 1'b0};
        tbl[2] = '{8'h43, 3, 1'b0, 1'b0};
        tbl[3] = '{8'h07, 3, 1'b0, 1'b0};
        tbl[4] = '{8'h08, 2, 1'b0, 1'b0};
        tbl[5] = '{8'h43, 3, 1'b0, 1'b0};
        tbl[6] = '{8'h7F, 3, 1'b0, 1'b0};
        tbl[7] = '{8'h1F, 3, 1'b0, 1'b0};

        @(negedge clock_25);
        do_reset("rst");
        send(1'b0, 8'h00, 1'b1, "rst_frame");

        // Table-driven editing of the working line.
        for (int i = 0; i < 8; i++) begin
            send(1'b1, tbl[i].b, 1'b0, "tbl");
            check("tbl_cursor_const", W'(cursor), W'(tbl[i].cur));
            check("tbl_full_const", W'(full), W'(tbl[i].fl));
            check("tbl_ovf_const", W'(overflow), W'(tbl[i].ov));
        end
        check("pre_frame_blank", disp_now(), '0);
        send(1'b0, 8'h00, 1'b1, "abc_frame");
        d = disp_now();
        check("abc_cells", W'(d[23:0]), W'(24'h434241));
        check("abc_rest_blank", W'(d[W-1:24]), '0);

        // CR, then held strobes and a frame pulse during the clear.
        send(1'b1, 8'h0D, 1'b0, "cr");
        low = 1;
        for (int k = 1; k <= 60; k++) begin
            char_valid = (k <= 10); char_in = 8'h41; frame_start = (k == 5);
            @(negedge clock_25);
            char_valid = 1'b0; frame_start = 1'b0;
            if (k == 5) check("clr_fs_ignored", disp_now(), m_disp);
            if (k == 6) check("clr_ovf_set", W'(overflow), W'(1));
            if (ready) break;
            low++;
        end
        check("clr_ready_low_cycles", W'(low), W'(41));
        $display("txn clear: ready low for %0d cycles", low);
        m_work = '0; m_dirty = 1'b1; m_overflow = 1'b0;
        check("clr_ovf_after", W'(overflow), W'(0));
        check("clr_disp_kept", disp_now(), m_disp);
        send(1'b0, 8'h00, 1'b1, "clr_frame");
        check("clr_frame_blank", disp_now(), '0);
        send(1'b1, 8'h08, 1'b0, "bs_at_zero");

        // Fill to the end, overflow, then back off one cell.
        for (int i = 0; i < N; i++) send(1'b1, 8'h30, 1'b0, "fill");
        check("fill_full", W'(full), W'(1));
        send(1'b1, 8'h31, 1'b0, "overfill");
        check("overfill_ovf", W'(overflow), W'(1));
        check("overfill_cursor", W'(cursor), W'(41));
        send(1'b0, 8'h00, 1'b1, "fill_frame");
        d = disp_now();
        check("fill_cell40", W'(d[8*40 +: 8]), W'(8'h30));
        send(1'b1, 8'h08, 1'b0, "bs_full");
        check("bs_full_cursor", W'(cursor), W'(40));
        check("bs_full_notfull", W'(full), W'(0));
        send(1'b0, 8'h00, 1'b1, "bs_frame");
        d = disp_now();
        check("bs_cell40", W'(d[8*40 +: 8]), W'(0));

        // Write coincident with a commit.
        send(1'b1, 8'h08, 1'b0, "bs_39");
        send(1'b1, 8'h5A, 1'b1, "same_cycle");
        d = disp_now();
        check("same_cycle_absent", W'(d[8*39 +: 8]), W'(0));
        send(1'b0, 8'h00, 1'b1, "same_next_frame");
        d = disp_now();
        check("same_cycle_shown", W'(d[8*39 +: 8]), W'(8'h5A));

        // Reset in the middle of a clear.
        send(1'b1, 8'h0A, 1'b0, "lf");
        repeat (19) @(negedge clock_25);
        check("mid_clear_busy", W'(ready), W'(0));
        do_reset("rst_mid_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
